adler32_chk: RTL and testbench

ADLER32_CHK -- requirements
Module: adler32_chk

---
 rtl/adler32_if.sv | 30 +++
 rtl/adler32_chk.sv | 129 ++++++++++++
 tb/tb_adler32_chk.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adler32_if.sv
// Adler-32 checker bus: stream beats, reference and result.
// Master drives the stream, slave is the checker.
interface adler32_if #(
  parameter int DATA_WD = 32
);
  logic               start_i;
  logic               val_i;
  logic [DATA_WD-1:0] dat_i;
  logic [1:0]         num_i;
  logic               lst_i;
  logic               ref_val_i;
  logic [DATA_WD-1:0] ref_i;
  logic               busy_o;
  logic               done_o;
  logic               val_o;
  logic [DATA_WD-1:0] dat_o;
  logic               err_o;

  modport master (
    output start_i, val_i, dat_i, num_i,
    output lst_i, ref_val_i, ref_i,
    input  busy_o, done_o, val_o, dat_o, err_o
  );

  modport slave (
    input  start_i, val_i, dat_i, num_i,
    input  lst_i, ref_val_i, ref_i,
    output busy_o, done_o, val_o, dat_o, err_o
  );
endinterface

// File: rtl/adler32_chk.sv
// Adler-32 stream checker: 4-byte beats folded per cycle,
// result compared with the zlib trailer reference.
module adler32_chk #(
  parameter int DATA_WD = 32
) (
  input logic      clk,
  input logic      rst,
  adler32_if.slave bus
);
  localparam int NB = DATA_WD / 8;
  localparam logic [19:0] MOD  = 20'd65521;
  localparam logic [19:0] MOD2 = 20'd131042;
  localparam logic [19:0] MOD4 = 20'd262084;

  typedef enum logic [1:0] {
    IDLE, RUN, WAIT_REF, CMP
  } state_t;

  state_t state;
  logic [15:0] a_q, b_q;
  logic ref_seen;
  logic [DATA_WD-1:0] ref_q;
  logic done_q, err_q, busy_q;
  logic [DATA_WD-1:0] dat_q;

  logic take;
  logic [2:0] n;
  logic [15:0] a_base, b_base;
  logic [15:0] a_nxt, b_nxt;
  logic [19:0] byte_v, sum_d, sum_w;
  logic [19:0] a_raw, b_raw, b_r1, b_r2;
  logic [DATA_WD-1:0] sum_ba, cmp_ref;

  assign take = bus.val_i &&
    (bus.start_i || state == RUN);
  assign sum_ba = {b_q, a_q};
  assign cmp_ref = bus.ref_val_i ?
    bus.ref_i : ref_q;

  // Fold one beat into A/B; B worst case stays below 8*MOD.
  always_comb begin
    n = (bus.num_i == 2'd0) ?
      3'd4 : {1'b0, bus.num_i};
    a_base = bus.start_i ? 16'd1 : a_q;
    b_base = bus.start_i ? 16'd0 : b_q;
    sum_d = 20'd0;
    sum_w = 20'd0;
    byte_v = 20'd0;
    for (int i = 0; i < NB; i++) begin
      byte_v = 20'(bus.dat_i[DATA_WD-1-8*i -: 8]);
      if (3'(i) < n) begin
        sum_d = sum_d + byte_v;
        sum_w = sum_w + byte_v * 20'(n - 3'(i));
      end
    end
    a_raw = 20'(a_base) + sum_d;
    a_nxt = (a_raw >= MOD) ?
      16'(a_raw - MOD) : 16'(a_raw);
    b_raw = 20'(b_base) +
      20'(n) * 20'(a_base) + sum_w;
    b_r1 = (b_raw >= MOD4) ? b_raw - MOD4 : b_raw;
    b_r2 = (b_r1 >= MOD2) ? b_r1 - MOD2 : b_r1;
    b_nxt = (b_r2 >= MOD) ?
      16'(b_r2 - MOD) : 16'(b_r2);
  end

  // Control FSM, checksum state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= 16'd1;
      b_q      <= 16'd0;
      ref_seen <= 1'b0;
      ref_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      dat_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start_i) begin
        ref_seen <= 1'b0;
        busy_q   <= 1'b1;
        a_q <= take ? a_nxt : 16'd1;
        b_q <= take ? b_nxt : 16'd0;
        state <= (take && bus.lst_i) ?
          WAIT_REF : RUN;
      end else begin
        unique case (state)
          IDLE: ;
          RUN: begin
            if (bus.ref_val_i) begin
              ref_q    <= bus.ref_i;
              ref_seen <= 1'b1;
            end
            if (take) begin
              a_q <= a_nxt;
              b_q <= b_nxt;
              if (bus.lst_i) state <= WAIT_REF;
            end
          end
          WAIT_REF: begin
            if (bus.ref_val_i) begin
              ref_q    <= bus.ref_i;
              ref_seen <= 1'b1;
            end
            if (ref_seen || bus.ref_val_i) begin
              done_q <= 1'b1;
              dat_q  <= sum_ba;
              err_q  <= (sum_ba != cmp_ref);
              state  <= CMP;
            end
          end
          CMP: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.val_o  = done_q;
  assign bus.dat_o  = dat_q;
  assign bus.err_o  = err_q;
endmodule

// File: tb/tb_adler32_chk.sv
// Bench for adler32_chk: byte-serial Adler-32 model,
// directed streams and timing checks.
module tb_adler32_chk;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adler32_if #(.DATA_WD(32)) bus ();

  adler32_chk #(.DATA_WD(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int t_beat = 0;
  logic armed = 1'b0;
  logic [31:0] exp_dat = '0;
  logic exp_err = 1'b0;
  logic [7:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] adler(
    input logic [7:0] d[$]
  );
    logic [31:0] a, b;
    a = 32'd1;
    b = 32'd0;
    foreach (d[i]) begin
      a = (a + 32'(d[i])) % 32'd65521;
      b = (b + a) % 32'd65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic check(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h",
        nm, act, exp);
    end
  endtask

  // Output compare against the model on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("val_eq_done",
        32'(bus.val_o), 32'(bus.done_o));
      if (bus.done_o) begin
        check("done_expected", 32'(armed), 32'd1);
        check("dat_o", bus.dat_o, exp_dat);
        check("err_o", 32'(bus.err_o), 32'(exp_err));
        armed = 1'b0;
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i   = 1'b0;
    bus.val_i     = 1'b0;
    bus.dat_i     = '0;
    bus.num_i     = 2'd0;
    bus.lst_i     = 1'b0;
    bus.ref_val_i = 1'b0;
    bus.ref_i     = '0;
  endtask

  task automatic put_beat(
    input logic [31:0] d,
    input logic [1:0] num,
    input logic lst
  );
    int nb;
    nb = (num == 2'd0) ? 4 : int'(num);
    bus.val_i = 1'b1;
    bus.dat_i = d;
    bus.num_i = num;
    bus.lst_i = lst;
    for (int i = 0; i < nb; i++)
      q.push_back(d[31-8*i -: 8]);
    t_beat = cyc;
  endtask

  task automatic beat(
    input logic [31:0] d,
    input logic [1:0] num,
    input logic lst
  );
    put_beat(d, num, lst);
    step();
    bus.val_i = 1'b0;
    bus.lst_i = 1'b0;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    q.delete();
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic give_ref(input logic [31:0] v);
    bus.ref_val_i = 1'b1;
    bus.ref_i = v;
    step();
    bus.ref_val_i = 1'b0;
  endtask

  task automatic arm(input logic [31:0] refv);
    exp_dat = adler(q);
    exp_err = (exp_dat != refv);
    armed = 1'b1;
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while (done_cnt == prev && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt == prev) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout act=none exp=pulse");
    end
  endtask

  task automatic pin(
    input string nm,
    input logic [31:0] exp
  );
    check(nm, adler(q), exp);
  endtask

  logic [31:0] v;
  longint bexp;
  int dc, s;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_dat", bus.dat_o, 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    step();

    // single beat, ref before lst, match
    s = cyc;
    bus.start_i = 1'b1;
    q.delete();
    @(negedge clk);
    check("t1_busy_s", 32'(bus.busy_o), 32'd0);
    step();
    bus.start_i = 1'b0;
    @(negedge clk);
    check("t1_busy_s1", 32'(bus.busy_o), 32'd1);
    give_ref(32'h0040001b);
    dc = done_cnt;
    beat(32'h04090409, 2'd0, 1'b1);
    pin("t1_model", 32'h0040001b);
    arm(32'h0040001b);
    wait_done(dc);
    check("t1_lat", 32'(done_cyc), 32'(t_beat + 2));
    check("t1_busy_done", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    check("t1_busy_after", 32'(bus.busy_o), 32'd0);
    check("t1_hold_dat", bus.dat_o, 32'h0040001b);
    step();

    // same stream, bad ref
    do_start();
    give_ref(32'h0040001c);
    dc = done_cnt;
    beat(32'h04090409, 2'd0, 1'b1);
    arm(32'h0040001c);
    wait_done(dc);
    check("t2_err_lit", 32'(bus.err_o), 32'd1);
    step();

    // Wikipedia with gaps, ref at T+1
    do_start();
    beat(32'h57696B69, 2'd0, 1'b0);
    repeat (2) step();
    beat(32'h70656469, 2'd0, 1'b0);
    step();
    dc = done_cnt;
    beat(32'h61000000, 2'd1, 1'b1);
    pin("t3_model", 32'h11E60398);
    arm(32'h11E60398);
    give_ref(32'h11E60398);
    wait_done(dc);
    check("t3_lat", 32'(done_cyc), 32'(t_beat + 2));
    step();

    // 1024 x 0xFFFFFFFF, wrong ref mid-stream
    do_start();
    for (int i = 0; i < 1024; i++) begin
      if (i == 500) bus.ref_val_i = 1'b1;
      bus.ref_i = 32'h0;
      beat(32'hFFFFFFFF, 2'd0, i == 1023);
      bus.ref_val_i = 1'b0;
    end
    dc = done_cnt;
    v = adler(q);
    check("t4_A", 32'(v[15:0]), 32'h0000F0E2);
    bexp = (4096 + 255 * 2048 * 4097) % 65521;
    check("t4_B", 32'(v[31:16]), 32'(bexp));
    arm(32'h0);
    wait_done(dc);
    check("t4_lat", 32'(done_cyc), 32'(t_beat + 2));
    step();

    // late ref: WAIT_REF for several cycles
    do_start();
    dc = done_cnt;
    beat(32'h61626300, 2'd3, 1'b1);
    pin("t5_model", 32'h024D0127);
    arm(32'h024D0127);
    repeat (4) step();
    @(negedge clk);
    check("t5_busy_wait", 32'(bus.busy_o), 32'd1);
    check("t5_no_done", 32'(done_cnt), 32'(dc));
    s = cyc;
    give_ref(32'h024D0127);
    wait_done(dc);
    check("t5_lat", 32'(done_cyc), 32'(s + 1));
    step();

    // reset mid-stream then abc
    do_start();
    give_ref(32'h12345678);
    beat(32'hDEADBEEF, 2'd0, 1'b0);
    beat(32'h01020304, 2'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(bus.busy_o), 32'd0);
    check("t6_dat", bus.dat_o, 32'd0);
    dc = done_cnt;
    repeat (3) step();
    do_start();
    beat(32'h61626300, 2'd3, 1'b1);
    arm(32'h024D0127);
    give_ref(32'h024D0127);
    wait_done(dc);
    check("t6_one_done", 32'(done_cnt), 32'(dc + 1));
    check("t6_dat_lit", bus.dat_o, 32'h024D0127);
    step();

    // abort via start in RUN
    dc = done_cnt;
    do_start();
    beat(32'h11223344, 2'd0, 1'b0);
    do_start();
    beat(32'h61626300, 2'd3, 1'b1);
    arm(32'h024D0127);
    give_ref(32'h024D0127);
    wait_done(dc);
    repeat (3) step();
    check("t7_one_done", 32'(done_cnt), 32'(dc + 1));

    // start with first beat in the same cycle
    dc = done_cnt;
    bus.start_i = 1'b1;
    q.delete();
    put_beat(32'h61626300, 2'd3, 1'b1);
    step();
    idle_inputs();
    arm(32'h0);
    give_ref(32'h0);
    wait_done(dc);
    check("t8_lat", 32'(done_cyc), 32'(t_beat + 2));
    check("t8_err_lit", 32'(bus.err_o), 32'd1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end
endmodule
